// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared funct3 codes, FSM states and byte-enable constants
package mem_lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0] BE_NONE = 4'b0000;
   localparam logic [3:0] BE_B    = 4'b0001;
   localparam logic [3:0] BE_H_LO = 4'b0011;
   localparam logic [3:0] BE_H_HI = 4'b1100;
   localparam logic [3:0] BE_W    = 4'b1111;

   // Stores only come in B/H/W; loads add the unsigned B/H variants
   function automatic logic f3_legal(input logic i_store, input logic [2:0] i_f3);
      return i_store ? (i_f3 == F3_B || i_f3 == F3_H || i_f3 == F3_W)
                     : (i_f3 == F3_B || i_f3 == F3_H || i_f3 == F3_W ||
                        i_f3 == F3_BU || i_f3 == F3_HU);
   endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// mem_lsu_align: store lane steering, load extraction/extension, access checks
module mem_lsu_align
   import mem_lsu_pkg::*;
(
   input  logic        i_is_store,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_off,
   input  logic [31:0] i_wdata,
   output logic [3:0]  o_be,
   output logic [31:0] o_wdata,
   output logic        o_misalign,
   output logic        o_illegal,
   input  logic [2:0]  i_ld_funct3,
   input  logic [1:0]  i_ld_off,
   input  logic [31:0] i_rdata,
   output logic [31:0] o_ld_data
);

   logic [31:0] w_shift;

   assign w_shift    = i_rdata >> {i_ld_off, 3'b000};
   assign o_misalign = (i_funct3[1:0] == 2'b01 && i_off[0]) || (i_funct3[1:0] == 2'b10 && i_off != 2'b00);
   assign o_illegal  = !f3_legal(i_is_store, i_funct3);

   // Store side: replicate data across lanes, enable only the addressed bytes
   always_comb begin
      o_be    = BE_NONE;
      o_wdata = '0;
      case (i_funct3)
         F3_B: begin
            o_be    = BE_B << i_off;
            o_wdata = {4{i_wdata[7:0]}};
         end
         F3_H: begin
            o_be    = i_off[1] ? BE_H_HI : BE_H_LO;
            o_wdata = {2{i_wdata[15:0]}};
         end
         F3_W: begin
            o_be    = BE_W;
            o_wdata = i_wdata;
         end
         default: ;
      endcase
   end

   // Load side: the addressed lane is shifted down to bit 0, then extended
   always_comb begin
      o_ld_data = '0;
      case (i_ld_funct3)
         F3_B:    o_ld_data = {{24{w_shift[7]}}, w_shift[7:0]};
         F3_H:    o_ld_data = {{16{w_shift[15]}}, w_shift[15:0]};
         F3_W:    o_ld_data = w_shift;
         F3_BU:   o_ld_data = {24'b0, w_shift[7:0]};
         F3_HU:   o_ld_data = {16'b0, w_shift[15:0]};
         default: ;
      endcase
   end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit with req/ack bus, pipeline stall and ack watchdog
module mem_lsu
   import mem_lsu_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_mem_memread,
   input  logic                  i_mem_memwrite,
   input  logic [ADDR_WIDTH-1:0] i_mem_alu_result,
   input  logic [DATA_WIDTH-1:0] i_mem_writedata,
   input  logic [2:0]            i_mem_funct3,
   output logic                  o_dmem_req,
   output logic                  o_dmem_we,
   output logic [ADDR_WIDTH-1:0] o_dmem_addr,
   output logic [DATA_WIDTH-1:0] o_dmem_wdata,
   output logic [3:0]            o_dmem_be,
   input  logic                  i_dmem_ack,
   input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
   output logic                  o_lsu_stall,
   output logic [DATA_WIDTH-1:0] o_lsu_rdata,
   output logic                  o_lsu_rvalid,
   output logic                  o_lsu_fault
);

   localparam int             CW       = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   state_t                r_state;
   logic [CW-1:0]         r_cnt;
   logic                  r_req;
   logic                  r_we;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [DATA_WIDTH-1:0] r_wdata;
   logic [3:0]            r_be;
   logic [2:0]            r_funct3;
   logic [1:0]            r_off;
   logic [DATA_WIDTH-1:0] r_rdata;
   logic                  r_rvalid;
   logic                  r_fault;

   logic                  w_access;
   logic                  w_store;
   logic                  w_bad;
   logic                  w_misalign;
   logic                  w_illegal;
   logic [3:0]            w_be;
   logic [DATA_WIDTH-1:0] w_wdata;
   logic [DATA_WIDTH-1:0] w_ld_data;
   logic                  w_idle;

   assign w_access = i_mem_memread | i_mem_memwrite;
   assign w_store  = i_mem_memwrite;
   assign w_bad    = w_misalign | w_illegal;
   assign w_idle   = r_state == S_IDLE;

   mem_lsu_align u_align (
      .i_is_store  (w_store),
      .i_funct3    (i_mem_funct3),
      .i_off       (i_mem_alu_result[1:0]),
      .i_wdata     (i_mem_writedata),
      .o_be        (w_be),
      .o_wdata     (w_wdata),
      .o_misalign  (w_misalign),
      .o_illegal   (w_illegal),
      .i_ld_funct3 (r_funct3),
      .i_ld_off    (r_off),
      .i_rdata     (i_dmem_rdata),
      .o_ld_data   (w_ld_data)
   );

   // Stall must freeze the pipeline in the same cycle a legal access is seen;
   // bad accesses fault immediately so the instruction can advance with its trap
   assign o_lsu_stall  = (r_state == S_BUSY) | (w_idle & w_access & ~w_bad);
   assign o_lsu_fault  = r_fault | (w_idle & w_access & w_bad);
   assign o_dmem_req   = r_req;
   assign o_dmem_we    = r_we;
   assign o_dmem_addr  = r_addr;
   assign o_dmem_wdata = r_wdata;
   assign o_dmem_be    = r_be;
   assign o_lsu_rdata  = r_rdata;
   assign o_lsu_rvalid = r_rvalid;

   // Access FSM: latch the request, hold the bus until ack or watchdog expiry
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state  <= S_IDLE;
         r_cnt    <= '0;
         r_req    <= 1'b0;
         r_we     <= 1'b0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_be     <= BE_NONE;
         r_funct3 <= F3_B;
         r_off    <= 2'b00;
         r_rdata  <= '0;
         r_rvalid <= 1'b0;
         r_fault  <= 1'b0;
      end else begin
         r_rvalid <= 1'b0;
         r_fault  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_access && !w_bad) begin
                  r_addr   <= {i_mem_alu_result[ADDR_WIDTH-1:2], 2'b00};
                  r_we     <= w_store;
                  r_be     <= w_store ? w_be : BE_NONE;
                  r_wdata  <= w_store ? w_wdata : '0;
                  r_funct3 <= i_mem_funct3;
                  r_off    <= i_mem_alu_result[1:0];
                  r_req    <= 1'b1;
                  r_cnt    <= '0;
                  r_state  <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (i_dmem_ack) begin
                  r_req    <= 1'b0;
                  r_rvalid <= ~r_we;
                  if (!r_we)
                     r_rdata <= w_ld_data;
                  r_state  <= S_DONE;
               end else if (r_cnt == CNT_LAST) begin
                  r_req    <= 1'b0;
                  r_fault  <= 1'b1;
                  r_rvalid <= ~r_we;
                  r_rdata  <= '0;
                  r_state  <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule
